// File: rtl/traffic_pkg.sv
// Shared encodings for the intersection controllers: per-road light code,
// phase state and the default timer width.
package traffic_pkg;
  typedef enum logic [1:0] {L_GREEN = 2'd0, L_YELLOW = 2'd1, L_RED = 2'd2} light_e;
  typedef enum logic [1:0] {S_ALL_RED = 2'd0, S_GREEN = 2'd1, S_YELLOW = 2'd2} phase_e;
  localparam int TIMER_WIDTH_DEF = 5;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request scanning upward from
// last_idx+1 with wrap, so the previously served index is considered last.
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_idx,
  output logic [IW-1:0] pick_idx,
  output logic          pick_valid
);
  int          w_j;
  logic [IW-1:0] w_cand;

  // Scan farthest-first so the nearest hit is the one left standing.
  always_comb begin
    pick_idx   = '0;
    pick_valid = 1'b0;
    w_j        = 0;
    w_cand     = '0;
    for (int k = N; k >= 1; k--) begin
      w_j    = (int'(last_idx) + k) % N;
      w_cand = IW'(w_j);
      if (req[w_cand]) begin
        pick_idx   = w_cand;
        pick_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/light_phase_arbiter.sv
// N-approach phase arbiter: one shared timer, round-robin GREEN grants with
// min/max green. Macro ALL_RED_CLEARANCE_EN enables the all-red clearance phase.
module light_phase_arbiter
  import traffic_pkg::*;
#(
  parameter  int N_APPROACH  = 4,
  parameter  int TIMER_WIDTH = TIMER_WIDTH_DEF,
  localparam int IW          = $clog2(N_APPROACH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_APPROACH-1:0]   car_present,
  input  logic [TIMER_WIDTH-1:0]  min_green_value,
  input  logic [TIMER_WIDTH-1:0]  max_green_value,
  input  logic [TIMER_WIDTH-1:0]  yellow_value,
  input  logic [TIMER_WIDTH-1:0]  all_red_value,
  output logic [2*N_APPROACH-1:0] light,
  output logic [IW-1:0]           active_idx,
  output logic                    green_valid
);
  phase_e                  r_state;
  logic [TIMER_WIDTH-1:0]  r_timer;
  logic [IW-1:0]           r_last;

  phase_e                  w_nstate;
  logic [IW-1:0]           w_nact, w_nlast, w_pick;
  logic                    w_pick_valid, w_clear_done, w_other_req;
  logic [TIMER_WIDTH-1:0]  w_max_eff;
  logic [N_APPROACH-1:0]   w_act_oh;
  logic [2*N_APPROACH-1:0] w_light;

  rr_pick #(.N(N_APPROACH)) u_pick (
    .req        (car_present),
    .last_idx   (r_last),
    .pick_idx   (w_pick),
    .pick_valid (w_pick_valid)
  );

`ifdef ALL_RED_CLEARANCE_EN
  assign w_clear_done = (r_timer >= all_red_value);
`else
  logic w_unused_all_red;
  assign w_unused_all_red = ^all_red_value;
  assign w_clear_done     = 1'b1;
`endif

  assign w_max_eff   = (max_green_value < min_green_value) ? min_green_value : max_green_value;
  assign w_act_oh    = N_APPROACH'(1) << active_idx;
  assign w_other_req = |(car_present & ~w_act_oh);

  always_comb begin
    w_nstate = r_state;
    w_nact   = active_idx;
    w_nlast  = r_last;
    case (r_state)
      S_ALL_RED:
        if (w_clear_done && w_pick_valid) begin
          w_nstate = S_GREEN;
          w_nact   = w_pick;
          w_nlast  = w_pick;
        end
      S_GREEN:
        if (r_timer >= min_green_value &&
            (!car_present[active_idx] || (r_timer >= w_max_eff && w_other_req)))
          w_nstate = S_YELLOW;
      S_YELLOW:
        if (r_timer >= yellow_value) begin
`ifdef ALL_RED_CLEARANCE_EN
          w_nstate = S_ALL_RED;
`else
          if (w_pick_valid) begin
            w_nstate = S_GREEN;
            w_nact   = w_pick;
            w_nlast  = w_pick;
          end else begin
            w_nstate = S_ALL_RED;
          end
`endif
        end
      default: w_nstate = S_ALL_RED;
    endcase
  end

  // Lights are decoded from next-state so the registered copy tracks r_state.
  always_comb begin
    w_light = '0;
    for (int i = 0; i < N_APPROACH; i++) begin
      w_light[2*i +: 2] = L_RED;
      if (IW'(i) == w_nact) begin
        if (w_nstate == S_GREEN)  w_light[2*i +: 2] = L_GREEN;
        if (w_nstate == S_YELLOW) w_light[2*i +: 2] = L_YELLOW;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_ALL_RED;
      r_timer     <= '0;
      active_idx  <= '0;
      r_last      <= IW'(N_APPROACH - 1);
      light       <= {N_APPROACH{L_RED}};
      green_valid <= 1'b0;
    end else begin
      r_state     <= w_nstate;
      active_idx  <= w_nact;
      r_last      <= w_nlast;
      light       <= w_light;
      green_valid <= (w_nstate == S_GREEN);
      if (w_nstate != r_state) r_timer <= '0;
      else if (!(&r_timer))    r_timer <= r_timer + 1'b1;
    end
  end
endmodule

// File: doc/light_phase_arbiter.md
# light_phase_arbiter

Multi-approach phase arbiter for an intersection of `N_APPROACH` roads. It shares one internal phase timer among all approaches and grants GREEN to exactly one requesting approach at a time, in round-robin order. Each grant is sequenced through GREEN, YELLOW and an optional all-red clearance. It sits above the per-road light drivers and generalises the two-road farm/highway controller to N roads with min/max green enforcement.

## Interface
- `N_APPROACH`, default 4: number of approaches; legal range 2..8.
- `TIMER_WIDTH`, default 5: width of the phase timer and of all duration inputs.
- `clk`, in, 1: single clock; all logic on posedge.
- `reset`, in, 1: synchronous, active-high reset. One clock, and reset is synchronous and active-high.
- `car_present`, in, `N_APPROACH`: per-approach request; bit i high means a car is waiting on approach i.
- `min_green_value`, in, `TIMER_WIDTH`: minimum GREEN timer count.
- `max_green_value`, in, `TIMER_WIDTH`: GREEN count after which a competing request forces a change.
- `yellow_value`, in, `TIMER_WIDTH`: YELLOW timer count.
- `all_red_value`, in, `TIMER_WIDTH`: clearance count. Ignored when the macro is off.
- `light`, out, `2*N_APPROACH`: bits [2i+1:2i] carry the light of approach i; GREEN=0, YELLOW=1, RED=2.
- `active_idx`, out, `$clog2(N_APPROACH)`: approach currently owning the phase.
- `green_valid`, out, 1: high while the phase state is GREEN.

## Operation
- States:
  - ALL_RED: every light RED.
  - GREEN: `active_idx` is GREEN, all others RED.
  - YELLOW: `active_idx` is YELLOW, all others RED.
- Reset values: state ALL_RED; timer 0; `active_idx` 0; `last_idx` N_APPROACH-1; all `light` fields RED; `green_valid` 0.
- Timer behaviour:
  - Cleared to 0 on every state change.
  - Otherwise increments by 1 per cycle and saturates at all-ones.
  - Every condition "timer >= V" is evaluated on the current registered timer.
- Round-robin pick: the first set bit of `car_present`, scanning from `last_idx`+1 upward with wrap. The previously served approach is therefore considered last.
- ALL_RED transitions:
  - Move to GREEN when clearance is done (timer >= `all_red_value`) and any `car_present` bit is set.
  - On that move, `active_idx` and `last_idx` are set to the picked approach.
  - With no request, stay in ALL_RED; the timer saturates.
- GREEN transitions (all require timer >= `min_green_value`):
  - Move to YELLOW if `car_present[active_idx]`==0.
  - Also move to YELLOW if timer >= `max_green_value` and any other approach is requesting.
  - If only the active approach requests, rest in GREEN indefinitely.
- YELLOW transition: move to ALL_RED when timer >= `yellow_value`.
- Duration inputs are sampled every cycle; a change takes effect on the next comparison.
- If `max_green_value` < `min_green_value`, the effective max is `min_green_value`.
- Invariant: at most one approach is non-RED in every cycle, and YELLOW is never adjacent to another approach's GREEN.
- Reset asserted in any state forces the reset values at the next edge; there is no partial-phase completion.

## Timing
- All outputs are registered and derived from the state and `active_idx` registers. There is no combinational input-to-output path.
- GREEN lasts at least `min_green_value`+1 cycles.
- YELLOW lasts exactly `yellow_value`+1 cycles.
- ALL_RED lasts at least `all_red_value`+1 cycles.
- A request rising while in ALL_RED with clearance already done produces GREEN at the next edge: 1 cycle latency.
- A `car_present` change is seen at the edge it is sampled, so a GREEN exit occurs one edge after the qualifying cycle.

## Configuration
- `ALL_RED_CLEARANCE_EN`:
  - Defined: behaviour as above.
  - Undefined: the clearance condition is treated as always true, and YELLOW exit goes straight to GREEN of the picked approach when any request is present, otherwise to ALL_RED. `all_red_value` is unused.

## Structure
- Shared package `traffic_pkg` holds:
  - the light encoding enum (GREEN/YELLOW/RED, 2-bit);
  - the phase state enum (ALL_RED/GREEN/YELLOW);
  - the default `TIMER_WIDTH`.
- Sub-module `rr_pick`: purely combinational round-robin selector. Inputs: request vector, `last_idx`. Outputs: `pick_idx`, `pick_valid`. It is reused by later multi-road controllers.
- The timer, state machine and light decode live in the top module.

## Test plan
All scenarios use N=4, min=3, max=10, yellow=2, all_red=1, macro defined unless stated.
1. Release reset with `car_present`=4'b0100 held: all RED for 2 cycles, then `light[5:4]`=GREEN, `active_idx`=2, `green_valid`=1.
2. Approach 0 granted, then `car_present`=0 on its first GREEN cycle: GREEN holds exactly 4 cycles, YELLOW 3 cycles, ALL_RED after; all other lights stay RED throughout.
3. `car_present`=4'b1111 continuously: grant order 0,1,2,3,0; each GREEN 11 cycles, YELLOW 3, ALL_RED 2.
4. Only the active approach requests: GREEN persists beyond 40 cycles. Raising bit 1 at cycle 40 gives YELLOW on the next edge.
5. Macro undefined with `car_present`=4'b0011: YELLOW of approach 0 is followed directly by GREEN of approach 1 with no all-red cycle.
6. Assert `reset` for 1 cycle mid-YELLOW: next edge all RED, `active_idx`=0, and the next grant goes to the lowest requesting index.
